// File: rtl/instr_byte_fetcher.sv
// rtl/instr_byte_fetcher.sv - byte-serial Y86-64 instruction fetcher
//
// Fetches one variable-length instruction (1..10 bytes) from a byte-wide,
// combinationally read instruction memory, one byte per clock.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        fetch request, accepted in IDLE, DONE or ERR
//   pc           byte address of the first instruction byte, sampled on accept
//   mem_addr     byte address presented to memory (0 outside FETCH)
//   mem_rdata    memory byte at mem_addr, valid in the same cycle
//   instr        assembled instruction, byte k at instr[8k:8k+7]
//   instr_len    instruction length in bytes
//   instr_ready  result outputs are final
//   busy         a fetch is in progress
//   instr_valid  icode is a defined Y86-64 code
//   imem_error   an address at or beyond MEM_SIZE was needed

module instr_byte_fetcher #(
    parameter int unsigned MEM_SIZE = 20480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] pc,
    output logic [63:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic [0:79] instr,
    output logic [3:0]  instr_len,
    output logic        instr_ready,
    output logic        busy,
    output logic        instr_valid,
    output logic        imem_error
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE,
        ERR
    } state_t;

    state_t      state;
    logic [63:0] pc_q;
    logic [3:0]  k;

    logic [64:0] addr_ext;
    logic        addr_oob;
    logic [3:0]  dec_len;
    logic        dec_valid;
    logic [3:0]  cur_len;
    logic        last_byte;

    // Length of an instruction from its icode nibble; undefined codes fetch
    // as a single byte so the fetcher always terminates.
    function automatic logic [3:0] len_of(input logic [3:0] icode);
        case (icode)
            4'h0, 4'h1, 4'h9:       len_of = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: len_of = 4'd2;
            4'h7, 4'h8:             len_of = 4'd9;
            4'h3, 4'h4, 4'h5:       len_of = 4'd10;
            default:                len_of = 4'd1;
        endcase
    endfunction

    // 65-bit sum so a pc near 2^64 cannot wrap back into the valid range.
    assign addr_ext  = {1'b0, pc_q} + {61'b0, k};
    assign addr_oob  = addr_ext >= 65'(MEM_SIZE);
    assign mem_addr  = (state == FETCH) ? addr_ext[63:0] : 64'd0;

    assign dec_len   = len_of(mem_rdata[7:4]);
    assign dec_valid = mem_rdata[7:4] <= 4'hB;

    // While byte 0 is on the bus the length is not registered yet, so the
    // decoder output is used directly to detect one-byte instructions.
    assign cur_len   = (k == 4'd0) ? dec_len : instr_len;
    assign last_byte = (k + 4'd1) == cur_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc_q        <= '0;
            k           <= '0;
            instr       <= '0;
            instr_len   <= '0;
            instr_ready <= 1'b0;
            busy        <= 1'b0;
            instr_valid <= 1'b0;
            imem_error  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state       <= FETCH;
                        pc_q        <= pc;
                        k           <= '0;
                        instr       <= '0;
                        instr_len   <= '0;
                        instr_ready <= 1'b0;
                        instr_valid <= 1'b0;
                        imem_error  <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                FETCH: begin
                    if (addr_oob) begin
                        // Bytes already captured are kept for debug.
                        state       <= ERR;
                        imem_error  <= 1'b1;
                        instr_ready <= 1'b1;
                        instr_valid <= 1'b0;
                        busy        <= 1'b0;
                    end else begin
                        instr[{k, 3'b000} +: 8] <= mem_rdata;
                        if (k == 4'd0) begin
                            instr_len   <= dec_len;
                            instr_valid <= dec_valid;
                        end
                        if (last_byte) begin
                            state       <= DONE;
                            instr_ready <= 1'b1;
                            busy        <= 1'b0;
                        end else begin
                            k <= k + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_byte_fetcher.sv
// tb/tb_instr_byte_fetcher.sv - self-checking bench for instr_byte_fetcher

module tb_instr_byte_fetcher;

    localparam int MEM = 20480;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] pc;
    logic [63:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [0:79] instr;
    logic [3:0]  instr_len;
    logic        instr_ready;
    logic        busy;
    logic        instr_valid;
    logic        imem_error;

    logic [7:0]  mem [0:MEM-1];

    int n_chk  = 0;
    int n_fail = 0;

    instr_byte_fetcher #(.MEM_SIZE(MEM)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pc          (pc),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_len   (instr_len),
        .instr_ready (instr_ready),
        .busy        (busy),
        .instr_valid (instr_valid),
        .imem_error  (imem_error)
    );

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 64'(MEM)) ? mem[mem_addr[14:0]] : 8'h00;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Transaction-level model: the whole fetch result is worked out when the
    // request is accepted; the timeline is then just a countdown.
    int          len_tbl [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
    logic [0:79] m_instr;
    logic [3:0]  m_len;
    logic        m_valid;
    logic        m_err;
    logic        m_busy;
    logic        m_ready;
    logic [63:0] m_pc;
    int          m_cnt;
    int          m_n;

    task automatic model_start(input logic [63:0] p);
        logic [64:0] a;
        logic [7:0]  b;
        int          len;
        len     = 1;
        m_instr = '0;
        m_len   = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_n     = 0;
        m_pc    = p;
        for (int i = 0; i < 10; i++) begin
            a = {1'b0, p} + 65'(i);
            if (a >= 65'(MEM)) begin
                m_err = 1'b1;
                m_n   = i + 1;
                break;
            end
            b = mem[a[14:0]];
            m_instr[8*i +: 8] = b;
            if (i == 0) begin
                len     = len_tbl[b[7:4]];
                m_len   = 4'(len);
                m_valid = b[7:4] <= 4'hB;
            end
            if (i + 1 == len) begin
                m_n = i + 1;
                break;
            end
        end
        if (m_err) m_valid = 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_ready = 1'b0;
            m_cnt   = 0;
            m_n     = 0;
            m_instr = '0;
            m_len   = '0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_pc    = '0;
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == m_n) begin
                m_busy  = 1'b0;
                m_ready = 1'b1;
            end
        end else if (start) begin
            model_start(pc);
            m_busy  = 1'b1;
            m_cnt   = 0;
            m_ready = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 80'(busy), 80'(m_busy));
            chk("mem_addr", 80'(mem_addr), m_busy ? 80'(m_pc + 64'(m_cnt)) : 80'd0);
            chk("instr_ready", 80'(instr_ready), 80'(m_ready));
            if (!m_busy) begin
                chk("instr", instr, m_instr);
                chk("instr_len", 80'(instr_len), 80'(m_len));
                chk("instr_valid", 80'(instr_valid), 80'(m_valid));
                chk("imem_error", 80'(imem_error), 80'(m_ready & m_err));
            end
        end
    end

    // Issue one fetch and count the busy cycles until the result is ready.
    task automatic do_fetch(input logic [63:0] p, input int exp_cycles, input string nm);
        int n;
        @(posedge clk);
        #1 start = 1'b1;
        pc = p;
        @(posedge clk);
        #1 start = 1'b0;
        pc = '0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk({nm, "_cycles"}, 80'(n), 80'(exp_cycles));
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_busy"}, 80'(busy), 80'd0);
        chk({nm, "_mem_addr"}, 80'(mem_addr), 80'd0);
        chk({nm, "_ready"}, 80'(instr_ready), 80'd0);
        chk({nm, "_instr"}, instr, 80'd0);
        chk({nm, "_len"}, 80'(instr_len), 80'd0);
        chk({nm, "_valid"}, 80'(instr_valid), 80'd0);
        chk({nm, "_err"}, 80'(imem_error), 80'd0);
    endtask

    logic [0:79] lit;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        pc    = '0;
        for (int i = 0; i < MEM; i++) mem[i] = 8'h00;
        mem[32] = 8'h61; mem[33] = 8'h23;
        mem[38] = 8'h00; mem[39] = 8'hC0;
        mem[40] = 8'h30; mem[41] = 8'hF2; mem[42] = 8'h0A;
        for (int i = 0; i < 9; i++) mem[50 + i] = 8'h70 + 8'(i);
        mem[60] = 8'hA0; mem[61] = 8'hAF;
        mem[62] = 8'hF0;
        mem[20478] = 8'h60; mem[20479] = 8'h30;

        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        do_fetch(64'd32, 2, "f32");
        lit = {8'h61, 8'h23, 64'h0};
        chk("lit_f32_instr", instr, lit);
        chk("lit_f32_len", 80'(instr_len), 80'd2);
        chk("lit_f32_valid", 80'(instr_valid), 80'd1);

        do_fetch(64'd40, 10, "f40");
        lit = {8'h30, 8'hF2, 8'h0A, 56'h0};
        chk("lit_f40_instr", instr, lit);
        chk("lit_f40_len", 80'(instr_len), 80'd10);

        do_fetch(64'd38, 1, "f38");
        chk("lit_f38_valid", 80'(instr_valid), 80'd1);
        do_fetch(64'd39, 1, "f39");
        chk("lit_f39_len", 80'(instr_len), 80'd1);
        chk("lit_f39_valid", 80'(instr_valid), 80'd0);

        do_fetch(64'd50, 9, "f50");
        do_fetch(64'd60, 2, "f60");
        do_fetch(64'd62, 1, "f62");
        repeat (3) @(posedge clk);
        do_fetch(64'd20478, 2, "f20478");

        do_fetch(64'd20479, 2, "f20479");
        chk("lit_err_flag", 80'(imem_error), 80'd1);
        chk("lit_err_ready", 80'(instr_ready), 80'd1);
        chk("lit_err_valid", 80'(instr_valid), 80'd0);
        chk("lit_err_byte0", 80'(instr[0:7]), 80'h30);

        do_fetch(64'd20480, 1, "f20480");
        do_fetch(64'hFFFF_FFFF_FFFF_FFFF, 1, "fwrap");
        chk("lit_wrap_err", 80'(imem_error), 80'd1);
        do_fetch(64'd32, 2, "f32_from_err");

        // Mid-fetch start pulse and reset.
        @(posedge clk);
        #1 start = 1'b1;
        pc = 64'd40;
        @(posedge clk);
        #1 start = 1'b0;
        pc = '0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        pc = 64'd32;
        @(posedge clk);
        #1 start = 1'b0;
        pc = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        do_fetch(64'd32, 2, "after_reset");
        lit = {8'h61, 8'h23, 64'h0};
        chk("lit_after_reset_instr", instr, lit);
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
